fft_bin_power: RTL and testbench
================================

Name: fft_bin_power

Overview:
- Downstream consumer of the 16-point FFT output stream (its out_push_F/out_real_F/out_imag_F; drives its out_stall).
- Computes per-bin power |X|^2 = re^2 + im^2 in a 2-stage pipeline and buffers results in a small FIFO with backpressure.
- Tracks the peak-power bin of every 16-bin frame and reports it once per frame.

Parameters:
- N_BINS, 16, bins per frame; bin counter width 4.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  single clock, all flops rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- in_push  in  1  sample valid from FFT.
- in_real  in  16  signed bin real part.
- in_imag  in  16  signed bin imag part.
- in_stall  out  1  backpressure to FFT (connects to its out_stall).
- out_push_F  out  1  registered power-sample valid.
- out_power_F  out  32  unsigned bin power.
- out_bin_F  out  4  bin index of out_power_F.
- out_stall  in  1  downstream backpressure.
- peak_valid_F  out  1  one-cycle pulse, frame peak ready.
- peak_bin_F  out  4  index of max-power bin in last frame.
- peak_power_F  out  32  power of that bin.
- overflow_err_F  out  1  sticky: push received while in_stall=1.

Behaviour:
- Reset (async, reset=0): all valids, counters, FIFO pointers/count, bin counter, peak tracker, overflow_err_F -> 0; out_power_F, out_bin_F, peak_bin_F, peak_power_F -> 0. Reset mid-frame discards in-flight and buffered data; the next accepted push after release is bin 0.
- Accept: in_push=1 and in_stall=0 at a rising edge. Bin counter increments per accepted push, wraps N_BINS-1 -> 0.
- in_push=1 while in_stall=1: sample dropped, bin counter unchanged, overflow_err_F set (cleared only by reset).
- Stage 1 (edge after accept): registers re*re, im*im (signed 16x16, each <= 2^30, held as 31-bit unsigned), bin index, valid.
- Stage 2: registers sum (32-bit unsigned; max 0x80000000 at (-32768,-32768); no overflow, no saturation), bin, valid.
- FIFO write when stage-2 valid; pop when FIFO non-empty and out_stall=0. Write and pop may occur on the same edge (count unchanged).
- Output register: on a pop edge out_push_F=1 and out_power_F/out_bin_F load the head entry; otherwise out_push_F=0 and the data registers hold.
- Minimum latency: accept at edge E0 -> out_push_F=1 after edge E3.
- Stall: in_stall = (fifo_count + s1_valid + s2_valid) >= FIFO_DEPTH. Combinational from registers only, so all in-flight samples always fit; no entry is ever lost or reordered.
- Peak tracker, updated on stage-2 valid:
  - bin 0 loads the tracker unconditionally.
  - Other bins replace the tracker only if power is strictly greater, so ties keep the lower index.
  - On stage-2 bin N_BINS-1: next edge, peak_valid_F=1 for one cycle and peak_bin_F/peak_power_F take the final result, which includes bin N_BINS-1.
  - Peak outputs ignore out_stall and hold until the next frame's report.

Test Plan:
- Single push (3,4), out_stall=0 -> out_push_F high exactly 3 cycles after the accept edge, out_power_F=25, out_bin_F=0.
- Push (-32768,-32768) -> out_power_F=0x80000000; push (-1,0) -> 1; (0,0) -> 0.
- Frame of 16 pushes: bin 5=(100,0), all others (1,1) -> peak_valid_F one pulse, peak_bin_F=5, peak_power_F=10000; 16 outputs, bins 0..15 in order, powers 2 except bin 5.
- Ties: bins 2 and 9 both (0,50), others 0 -> peak_bin_F=2, peak_power_F=2500.
- Backpressure: out_stall=1 with continuous in_push -> in_stall rises once 4 samples are in flight/buffered. Release out_stall -> all 16 outputs delivered in order, none lost, overflow_err_F=0. Forcing a push during in_stall -> overflow_err_F=1 and bin counter unchanged.
- Reset pulse after bin 7 -> all outputs 0 immediately. Next frame starts at bin 0 and produces a correct peak report with no stale entries.

Source files
------------

// File: rtl/fft_bin_power.sv
// rtl/fft_bin_power.sv - per-bin |X|^2 pipeline with output FIFO and frame peak tracker
module fft_bin_power #(
  parameter int N_BINS     = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int BIN_W     = $clog2(N_BINS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_push,
  input  logic signed [15:0]      in_real,
  input  logic signed [15:0]      in_imag,
  output logic                    in_stall,
  output logic                    out_push_F,
  output logic [31:0]             out_power_F,
  output logic [BIN_W-1:0]        out_bin_F,
  input  logic                    out_stall,
  output logic                    peak_valid_F,
  output logic [BIN_W-1:0]        peak_bin_F,
  output logic [31:0]             peak_power_F,
  output logic                    overflow_err_F
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);

  logic [BIN_W-1:0] bin_cnt;
  logic             accept;

  logic signed [31:0] re_ext, im_ext;
  logic [30:0]        re_sq, im_sq;

  logic               s1_valid;
  logic [30:0]        s1_sq_re, s1_sq_im;
  logic [BIN_W-1:0]   s1_bin;

  logic               s2_valid;
  logic [31:0]        s2_power;
  logic [BIN_W-1:0]   s2_bin;

  logic [31:0]        fifo_pow [FIFO_DEPTH];
  logic [BIN_W-1:0]   fifo_bin [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_push, fifo_pop;
  logic [OCC_W-1:0]   occupancy;

  logic [BIN_W-1:0]   pk_bin, nxt_pk_bin;
  logic [31:0]        pk_power, nxt_pk_power;

  // Stall counts everything already committed downstream, so any accepted
  // sample is guaranteed a FIFO slot regardless of out_stall.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
  assign in_stall  = occupancy >= OCC_W'(FIFO_DEPTH);
  assign accept    = in_push && !in_stall;

  assign re_ext = 32'(in_real);
  assign im_ext = 32'(in_imag);
  assign re_sq  = 31'(re_ext * re_ext);
  assign im_sq  = 31'(im_ext * im_ext);

  assign fifo_push = s2_valid;
  assign fifo_pop  = (fifo_count != '0) && !out_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt        <= '0;
      overflow_err_F <= 1'b0;
      s1_valid       <= 1'b0;
      s1_sq_re       <= '0;
      s1_sq_im       <= '0;
      s1_bin         <= '0;
      s2_valid       <= 1'b0;
      s2_power       <= '0;
      s2_bin         <= '0;
    end else begin
      if (in_push && in_stall) overflow_err_F <= 1'b1;
      if (accept) bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_sq_re <= re_sq;
        s1_sq_im <= im_sq;
        s1_bin   <= bin_cnt;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_power <= {1'b0, s1_sq_re} + {1'b0, s1_sq_im};
        s2_bin   <= s1_bin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pow[wr_ptr] <= s2_power;
      fifo_bin[wr_ptr] <= s2_bin;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      out_push_F  <= 1'b0;
      out_power_F <= '0;
      out_bin_F   <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      out_push_F <= fifo_pop;
      if (fifo_pop) begin
        out_power_F <= fifo_pow[rd_ptr];
        out_bin_F   <= fifo_bin[rd_ptr];
      end
    end
  end

  // Bin 0 seeds the tracker; strict compare keeps the lowest index on ties.
  always_comb begin
    nxt_pk_bin   = pk_bin;
    nxt_pk_power = pk_power;
    if (s2_valid && (s2_bin == '0 || s2_power > pk_power)) begin
      nxt_pk_bin   = s2_bin;
      nxt_pk_power = s2_power;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pk_bin       <= '0;
      pk_power     <= '0;
      peak_valid_F <= 1'b0;
      peak_bin_F   <= '0;
      peak_power_F <= '0;
    end else begin
      pk_bin       <= nxt_pk_bin;
      pk_power     <= nxt_pk_power;
      peak_valid_F <= s2_valid && (s2_bin == LAST_BIN);
      if (s2_valid && (s2_bin == LAST_BIN)) begin
        peak_bin_F   <= nxt_pk_bin;
        peak_power_F <= nxt_pk_power;
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_power.sv
// tb/tb_fft_bin_power.sv - directed self-checking bench for fft_bin_power
module tb_fft_bin_power;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_push;
  logic signed [15:0] in_real, in_imag;
  logic               in_stall;
  logic               out_push_F;
  logic [31:0]        out_power_F;
  logic [3:0]         out_bin_F;
  logic               out_stall;
  logic               peak_valid_F;
  logic [3:0]         peak_bin_F;
  logic [31:0]        peak_power_F;
  logic               overflow_err_F;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_pow [$];
  logic [3:0]  cap_bin [$];
  logic [31:0] pk_pow  [$];
  logic [3:0]  pk_bin  [$];

  fft_bin_power dut (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall), .out_push_F(out_push_F), .out_power_F(out_power_F),
    .out_bin_F(out_bin_F), .out_stall(out_stall), .peak_valid_F(peak_valid_F),
    .peak_bin_F(peak_bin_F), .peak_power_F(peak_power_F), .overflow_err_F(overflow_err_F)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (out_push_F) begin
      cap_pow.push_back(out_power_F);
      cap_bin.push_back(out_bin_F);
    end
    if (peak_valid_F) begin
      pk_pow.push_back(peak_power_F);
      pk_bin.push_back(peak_bin_F);
    end
  end

  task automatic clear_caps();
    cap_pow.delete(); cap_bin.delete(); pk_pow.delete(); pk_bin.delete();
  endtask

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    in_real = re; in_imag = im; in_push = 1'b1;
    @(negedge clk);
    in_push = 1'b0;
  endtask

  // Pushes samples (i,0) for i=first..first+n-1, honouring in_stall.
  task automatic feed(input int first, input int n, input int release_cyc,
                      output int sent, output int stall_at);
    int cyc = 0;
    sent = 0; stall_at = -1;
    while (sent < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      in_push = 1'b0;
      if (in_stall && stall_at < 0) stall_at = sent;
      if (cyc == release_cyc) out_stall = 1'b0;
      if (!in_stall && sent < n) begin
        in_real = 16'(first + sent); in_imag = 0; in_push = 1'b1; sent++;
      end
    end
    @(negedge clk);
    in_push = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_push_F !== 1'b0) begin errors++; $display("FAIL reset_out_push got=%0b exp=0", out_push_F); end
    checks++; if (out_power_F !== 32'd0) begin errors++; $display("FAIL reset_out_power got=%0h exp=0", out_power_F); end
    checks++; if (peak_valid_F !== 1'b0 || peak_bin_F !== 4'd0 || peak_power_F !== 32'd0) begin errors++; $display("FAIL reset_peak got=%0b/%0d/%0h exp=0/0/0", peak_valid_F, peak_bin_F, peak_power_F); end
    checks++; if (in_stall !== 1'b0 || overflow_err_F !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b/%0b exp=0/0", in_stall, overflow_err_F); end
  endtask

  task automatic test_latency();
    logic exp;
    clear_caps();
    in_real = 3; in_imag = 4; in_push = 1'b1;
    @(posedge clk);
    #1 in_push = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = (k == 3);
      checks++; if (out_push_F !== exp) begin errors++; $display("FAIL latency_push_e%0d got=%0b exp=%0b", k, out_push_F, exp); end
      if (k == 3) begin
        checks++; if (out_power_F !== 32'd25 || out_bin_F !== 4'd0) begin errors++; $display("FAIL latency_data got=%0d/bin%0d exp=25/bin0", out_power_F, out_bin_F); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    logic [31:0] ep [3];
    ep[0] = 32'h80000000; ep[1] = 32'd1; ep[2] = 32'd0;
    clear_caps();
    send(-16'sd32768, -16'sd32768);
    send(-16'sd1, 16'sd0);
    send(16'sd0, 16'sd0);
    repeat (8) @(negedge clk);
    checks++; if (cap_pow.size() != 3) begin errors++; $display("FAIL extreme_count got=%0d exp=3", cap_pow.size()); end
    for (int i = 0; i < 3 && i < cap_pow.size(); i++) begin
      checks++; if (cap_pow[i] !== ep[i] || cap_bin[i] !== 4'(i + 1)) begin errors++; $display("FAIL extreme_%0d got=%0h/bin%0d exp=%0h/bin%0d", i, cap_pow[i], cap_bin[i], ep[i], i + 1); end
    end
    for (int i = 4; i < 16; i++) send(0, 0);
    repeat (8) @(negedge clk);
    checks++; if (pk_pow.size() != 1) begin errors++; $display("FAIL extreme_peak_count got=%0d exp=1", pk_pow.size()); end
    else begin
      checks++; if (pk_bin[0] !== 4'd1 || pk_pow[0] !== 32'h80000000) begin errors++; $display("FAIL extreme_peak got=bin%0d/%0h exp=bin1/80000000", pk_bin[0], pk_pow[0]); end
    end
  endtask

  task automatic test_frame_peak();
    logic [31:0] exp;
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) send(100, 0); else send(1, 1);
    end
    repeat (8) @(negedge clk);
    checks++; if (cap_pow.size() != 16) begin errors++; $display("FAIL frame_count got=%0d exp=16", cap_pow.size()); end
    for (int i = 0; i < 16 && i < cap_pow.size(); i++) begin
      exp = (i == 5) ? 32'd10000 : 32'd2;
      checks++; if (cap_pow[i] !== exp || cap_bin[i] !== 4'(i)) begin errors++; $display("FAIL frame_out_%0d got=%0d/bin%0d exp=%0d/bin%0d", i, cap_pow[i], cap_bin[i], exp, i); end
    end
    checks++; if (pk_pow.size() != 1) begin errors++; $display("FAIL frame_peak_pulses got=%0d exp=1", pk_pow.size()); end
    else begin
      checks++; if (pk_bin[0] !== 4'd5 || pk_pow[0] !== 32'd10000) begin errors++; $display("FAIL frame_peak got=bin%0d/%0d exp=bin5/10000", pk_bin[0], pk_pow[0]); end
    end
  endtask

  task automatic test_ties();
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 9) send(0, 50); else send(0, 0);
    end
    repeat (8) @(negedge clk);
    checks++; if (pk_pow.size() != 1) begin errors++; $display("FAIL tie_peak_pulses got=%0d exp=1", pk_pow.size()); end
    else begin
      checks++; if (pk_bin[0] !== 4'd2 || pk_pow[0] !== 32'd2500) begin errors++; $display("FAIL tie_peak got=bin%0d/%0d exp=bin2/2500", pk_bin[0], pk_pow[0]); end
    end
  endtask

  task automatic test_backpressure();
    int sent, stall_at, sent2, stall2;
    clear_caps();
    out_stall = 1'b1;
    feed(0, 16, 30, sent, stall_at);
    repeat (10) @(negedge clk);
    checks++; if (sent != 16) begin errors++; $display("FAIL bp_feed_timeout got=%0d exp=16", sent); end
    checks++; if (stall_at != 4) begin errors++; $display("FAIL bp_stall_point got=%0d exp=4", stall_at); end
    checks++; if (cap_pow.size() != 16) begin errors++; $display("FAIL bp_count got=%0d exp=16", cap_pow.size()); end
    for (int i = 0; i < 16 && i < cap_pow.size(); i++) begin
      checks++; if (cap_pow[i] !== 32'(i * i) || cap_bin[i] !== 4'(i)) begin errors++; $display("FAIL bp_out_%0d got=%0d/bin%0d exp=%0d/bin%0d", i, cap_pow[i], cap_bin[i], i * i, i); end
    end
    checks++; if (overflow_err_F !== 1'b0) begin errors++; $display("FAIL bp_no_overflow got=%0b exp=0", overflow_err_F); end

    clear_caps();
    out_stall = 1'b1;
    feed(0, 4, -1, sent, stall_at);
    repeat (3) @(negedge clk);
    checks++; if (in_stall !== 1'b1 || cap_pow.size() != 0) begin errors++; $display("FAIL bp_held got=stall%0b/outs%0d exp=stall1/outs0", in_stall, cap_pow.size()); end
    send(7, 7);
    checks++; if (overflow_err_F !== 1'b1) begin errors++; $display("FAIL bp_overflow got=%0b exp=1", overflow_err_F); end
    out_stall = 1'b0;
    feed(4, 12, -1, sent2, stall2);
    repeat (10) @(negedge clk);
    checks++; if (cap_pow.size() != 16) begin errors++; $display("FAIL bp_drop_count got=%0d exp=16", cap_pow.size()); end
    for (int i = 0; i < 16 && i < cap_pow.size(); i++) begin
      checks++; if (cap_pow[i] !== 32'(i * i) || cap_bin[i] !== 4'(i)) begin errors++; $display("FAIL bp_drop_out_%0d got=%0d/bin%0d exp=%0d/bin%0d", i, cap_pow[i], cap_bin[i], i * i, i); end
    end
    checks++; if (pk_pow.size() != 1 || pk_bin[0] !== 4'd15 || pk_pow[0] !== 32'd225) begin errors++; $display("FAIL bp_peak got=n%0d exp=n1 bin15/225", pk_pow.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    clear_caps();
    for (int i = 0; i < 8; i++) send(16'(i + 1), 0);
    reset = 1'b0;
    #1;
    checks++; if (out_push_F !== 1'b0 || out_power_F !== 32'd0 || out_bin_F !== 4'd0) begin errors++; $display("FAIL rst_mid_out got=%0b/%0h/%0d exp=0/0/0", out_push_F, out_power_F, out_bin_F); end
    checks++; if (peak_bin_F !== 4'd0 || peak_power_F !== 32'd0 || peak_valid_F !== 1'b0) begin errors++; $display("FAIL rst_mid_peak got=%0d/%0h exp=0/0", peak_bin_F, peak_power_F); end
    checks++; if (overflow_err_F !== 1'b0 || in_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%0b/%0b exp=0/0", overflow_err_F, in_stall); end
    @(negedge clk);
    reset = 1'b1;
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) send(20, 20); else send(2, 0);
    end
    repeat (8) @(negedge clk);
    checks++; if (cap_pow.size() != 16) begin errors++; $display("FAIL rst_frame_count got=%0d exp=16", cap_pow.size()); end
    for (int i = 0; i < 16 && i < cap_pow.size(); i++) begin
      exp = (i == 3) ? 32'd800 : 32'd4;
      checks++; if (cap_pow[i] !== exp || cap_bin[i] !== 4'(i)) begin errors++; $display("FAIL rst_frame_out_%0d got=%0d/bin%0d exp=%0d/bin%0d", i, cap_pow[i], cap_bin[i], exp, i); end
    end
    checks++; if (pk_pow.size() != 1) begin errors++; $display("FAIL rst_peak_pulses got=%0d exp=1", pk_pow.size()); end
    else begin
      checks++; if (pk_bin[0] !== 4'd3 || pk_pow[0] !== 32'd800) begin errors++; $display("FAIL rst_peak got=bin%0d/%0d exp=bin3/800", pk_bin[0], pk_pow[0]); end
    end
  endtask

  initial begin
    reset = 1'b0; in_push = 1'b0; in_real = 0; in_imag = 0; out_stall = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_latency();
    test_extremes();
    test_frame_peak();
    test_ties();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
